// File: rtl/diners_pkg.sv
// Shared seat state encoding and ring-neighbour helpers for the fork waiter.
// Helpers take the ring size explicitly so they work for any table size.
package diners_pkg;

    typedef enum logic [1:0] {
        THINKING = 2'd0,
        HUNGRY   = 2'd1,
        EATING   = 2'd2,
        READING  = 2'd3
    } t_state;

    function automatic int left_of(input int i, input int n);
        return (i + n - 1) % n;
    endfunction

    function automatic int right_of(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/seat_fsm.sv
// One seat: THINKING/HUNGRY/EATING register, hungry-wait and eat-length counters, starve flag.
// Starvation monitor is built only when FORK_WAITER_STARVE_MON_EN is defined.
module seat_fsm
    import diners_pkg::*;
#(
    parameter int AGE_LIMIT    = 8,
`ifdef FORK_WAITER_STARVE_MON_EN
    parameter int STARVE_LIMIT = 32,
`endif
    parameter int EAT_MAX      = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hungry_req,
    input  logic   done,
    input  logic   grant,
    output t_state state,
    output logic   aged,
    output logic   starve_flag
);

`ifdef FORK_WAITER_STARVE_MON_EN
    localparam int WAIT_REF = (AGE_LIMIT > STARVE_LIMIT) ? AGE_LIMIT : STARVE_LIMIT;
`else
    localparam int WAIT_REF = AGE_LIMIT;
`endif
    localparam int WW = $clog2(WAIT_REF + 1);
    localparam int EW = (EAT_MAX > 1) ? $clog2(EAT_MAX) : 1;
    localparam logic [WW-1:0] WAIT_SAT = '1;

    t_state        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic [EW-1:0] eat_cnt;
    logic [EW-1:0] eat_nxt;
    logic          release_now;

    always_comb begin
        release_now = done || (eat_cnt == EW'(EAT_MAX - 1));
        state_nxt   = THINKING;
        wait_nxt    = '0;
        eat_nxt     = '0;
        case (state)
            THINKING: state_nxt = hungry_req ? HUNGRY : THINKING;
            HUNGRY:   state_nxt = grant ? EATING : HUNGRY;
            EATING:   state_nxt = release_now ? THINKING : EATING;
            default:  state_nxt = THINKING;
        endcase
        if (state == HUNGRY && !grant) begin
            wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + WW'(1);
        end
        if (state == EATING && !release_now) begin
            eat_nxt = eat_cnt + EW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= THINKING;
            wait_cnt <= '0;
            eat_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            eat_cnt  <= eat_nxt;
        end
    end

    assign aged = (wait_cnt >= WW'(AGE_LIMIT));

`ifdef FORK_WAITER_STARVE_MON_EN
    logic starve_q;

    // Sticky until reset; a later meal does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 1'b0;
        end else if (wait_nxt >= WW'(STARVE_LIMIT)) begin
            starve_q <= 1'b1;
        end
    end

    assign starve_flag = starve_q;
`else
    assign starve_flag = 1'b0;
`endif

endmodule

// File: rtl/fork_waiter.sv
// Central waiter for an N-seat table: aged-first then round-robin fork grants, one grant cycle.
// Optional starvation monitor under FORK_WAITER_STARVE_MON_EN; outputs are registered seat state.
module fork_waiter
    import diners_pkg::*;
#(
    parameter int N            = 5,
    parameter int AGE_LIMIT    = 8,
    parameter int EAT_MAX      = 16,
    parameter int STARVE_LIMIT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   hungry_req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   eat_grant,
    output logic [2*N-1:0] seat_state,
    output logic [N-1:0]   starve_flag
);

    localparam int RW = $clog2(N);

    if (N < 3 || N > 16 || AGE_LIMIT < 1 || EAT_MAX < 1 || STARVE_LIMIT < 1) begin : g_param_check
        $error("fork_waiter: parameter out of range");
    end

    t_state        st [N];
    logic [N-1:0]  hungry;
    logic [N-1:0]  eating;
    logic [N-1:0]  aged;
    logic [N-1:0]  grant;
    logic [RW-1:0] rr_ptr;
    logic [RW-1:0] rr_nxt;

    for (genvar g = 0; g < N; g++) begin : g_seat
        seat_fsm #(
            .AGE_LIMIT   (AGE_LIMIT),
`ifdef FORK_WAITER_STARVE_MON_EN
            .STARVE_LIMIT(STARVE_LIMIT),
`endif
            .EAT_MAX     (EAT_MAX)
        ) u_seat (
            .clk        (clk),
            .rst        (rst),
            .hungry_req (hungry_req[g]),
            .done       (done[g]),
            .grant      (grant[g]),
            .state      (st[g]),
            .aged       (aged[g]),
            .starve_flag(starve_flag[g])
        );
        assign hungry[g]          = (st[g] == HUNGRY);
        assign eating[g]          = (st[g] == EATING);
        assign eat_grant[g]       = eating[g];
        assign seat_state[2*g+:2] = st[g];
    end

    // Neighbour test uses registered state, so a fork freed this cycle is only reusable next cycle.
    always_comb begin
        logic [RW-1:0] lft;
        logic [RW-1:0] rgt;
        logic [RW-1:0] idx;
        logic [RW-1:0] last_rr;
        logic          rr_hit;
        grant   = '0;
        lft     = '0;
        rgt     = '0;
        idx     = '0;
        last_rr = '0;
        rr_hit  = 1'b0;
        for (int i = 0; i < N; i++) begin
            lft = RW'(left_of(i, N));
            rgt = RW'(right_of(i, N));
            if (hungry[i] && aged[i] && !eating[lft] && !eating[rgt] && !grant[lft] && !grant[rgt]) begin
                grant[i] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            idx = RW'((int'(rr_ptr) + k) % N);
            lft = RW'(left_of(int'(idx), N));
            rgt = RW'(right_of(int'(idx), N));
            if (hungry[idx] && !grant[idx] && !eating[lft] && !eating[rgt] && !grant[lft] && !grant[rgt]) begin
                grant[idx] = 1'b1;
                last_rr    = idx;
                rr_hit     = 1'b1;
            end
        end
        rr_nxt = rr_hit ? RW'(right_of(int'(last_rr), N)) : rr_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_nxt;
        end
    end

endmodule
